// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, a link write port and a
// per-register busy scoreboard for the ID stage hazard unit.
module regfile_scoreboard #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter int                SP_INDEX   = 29,
    parameter logic [DATA_W-1:0] SP_RESET   = 32'h00000FFC,
    parameter int                LINK_INDEX = 31,
    parameter bit                BYPASS     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              link,
    input  logic [DATA_W-1:0] link_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr
);

    localparam int                NREG   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_INDEX);
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;

    // Qualified write/issue strobes; register 0 is never a target.
    logic w_link_we;
    logic w_wr_we;
    logic w_wr_commit;
    logic w_issue_set;
    logic w_bypass_on;

    // Decode which updates are live this cycle.
    always_comb begin
        w_link_we   = link && (LINK_A != ZERO_A);
        w_wr_we     = wr_en && (wr_addr != ZERO_A);
        // A link to the same register takes precedence over the writeback.
        w_wr_commit = w_wr_we && !(w_link_we && (wr_addr == LINK_A));
        w_issue_set = issue_en && (issue_addr != ZERO_A);
        w_bypass_on = BYPASS && !freeze;
    end

    // Register array: reset loads SP, otherwise commit writes unless frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else if (!freeze) begin
            if (w_wr_commit) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (w_link_we) begin
                r_regs[LINK_A] <= link_data;
            end
        end
    end

    // Scoreboard: writeback clears, issue sets; the later set wins on a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else if (!freeze) begin
            if (w_wr_we) begin
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_issue_set) begin
                r_busy[issue_addr] <= 1'b1;
            end
        end
    end

    // Read data with optional forwarding of this cycle's link/writeback.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        if (addr == ZERO_A) begin
            v = '0;
        end else if (w_bypass_on && w_link_we && (addr == LINK_A)) begin
            v = link_data;
        end else if (w_bypass_on && w_wr_we && (addr == wr_addr)) begin
            v = wr_data;
        end else begin
            v = r_regs[addr];
        end
        return v;
    endfunction

    // Busy status, hidden when this cycle's writeback retires the producer
    // and no new producer issues to the same register.
    function automatic logic busy_port(input logic [ADDR_W-1:0] addr);
        logic b;
        if (addr == ZERO_A) begin
            b = 1'b0;
        end else if (w_bypass_on && w_wr_we && (addr == wr_addr) &&
                     !(w_issue_set && (addr == issue_addr))) begin
            b = 1'b0;
        end else begin
            b = r_busy[addr];
        end
        return b;
    endfunction

    // Drive both read ports combinationally.
    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
        busy1    = busy_port(rd_addr1);
        busy2    = busy_port(rd_addr2);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard, with a BYPASS=1 and a BYPASS=0
// instance driven by the same inputs.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset, freeze, link, wr_en, issue_en;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic [31:0] link_data, wr_data;
    logic [31:0] rd_data1, rd_data2, nb_rd_data1, nb_rd_data2;
    logic        busy1, busy2, nb_busy1, nb_busy2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .busy1(busy1), .busy2(busy2),
        .link(link), .link_data(link_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    regfile_scoreboard #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .freeze(freeze),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
        .busy1(nb_busy1), .busy2(nb_busy2),
        .link(link), .link_data(link_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        link = 0; wr_en = 0; issue_en = 0; freeze = 0;
        link_data = '0; wr_data = '0; wr_addr = '0; issue_addr = '0;
    endtask

    initial begin
        idle();
        reset = 1; rd_addr1 = 0; rd_addr2 = 0;
        tick();
        reset = 0;

        // T1: reset state
        for (int r = 0; r < 32; r++) begin
            rd_addr1 = 5'(r); rd_addr2 = 5'(r); #1;
            chk($sformatf("T1_reg%0d", r), rd_data1, (r == 29) ? 32'h00000FFC : 32'h0);
            chk($sformatf("T1_busy%0d", r), {31'b0, busy1 | busy2}, 32'h0);
        end

        // T2: write to reg 0 ignored, write to reg 5 with bypass
        wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF; rd_addr1 = 0; #1;
        chk("T2_r0_bypass", rd_data1, 32'h0);
        tick();
        chk("T2_r0_after", rd_data1, 32'h0);
        wr_addr = 5; rd_addr1 = 5; #1;
        chk("T2_r5_bypass", rd_data1, 32'hDEADBEEF);
        chk("T2_r5_nobypass", nb_rd_data1, 32'h0);
        tick();
        idle(); #1;
        chk("T2_r5_stored", rd_data1, 32'hDEADBEEF);
        chk("T2_r5_stored_nb", nb_rd_data1, 32'hDEADBEEF);

        // T3: link beats writeback on reg 31
        link = 1; link_data = 32'h40; wr_en = 1; wr_addr = 31; wr_data = 32'h99; rd_addr1 = 31; #1;
        chk("T3_bypass_link", rd_data1, 32'h40);
        tick();
        idle(); #1;
        chk("T3_r31", rd_data1, 32'h40);
        chk("T3_r31_nb", nb_rd_data1, 32'h40);

        // T4: scoreboard set / set-wins / clear
        issue_en = 1; issue_addr = 8; tick();
        idle(); rd_addr1 = 8; #1;
        chk("T4_busy_set", {31'b0, busy1}, 32'h1);
        wr_en = 1; wr_addr = 8; wr_data = 32'h1234; issue_en = 1; issue_addr = 8; #1;
        chk("T4_busy_reissue_comb", {31'b0, busy1}, 32'h1);
        tick();
        idle(); #1;
        chk("T4_busy_setwins", {31'b0, busy1}, 32'h1);
        wr_en = 1; wr_addr = 8; wr_data = 32'h5678; #1;
        chk("T4_busy_bypass_clear", {31'b0, busy1}, 32'h0);
        chk("T4_busy_nb_still", {31'b0, nb_busy1}, 32'h1);
        tick();
        idle(); #1;
        chk("T4_busy_cleared", {31'b0, busy1}, 32'h0);
        chk("T4_r8", rd_data1, 32'h5678);
        issue_en = 1; issue_addr = 0; tick();
        idle(); rd_addr1 = 0; #1;
        chk("T4_r0_never_busy", {31'b0, busy1}, 32'h0);

        // T5: freeze holds everything, then inputs commit
        freeze = 1; wr_en = 1; wr_addr = 10; wr_data = 32'hAAAA;
        link = 1; link_data = 32'h77; issue_en = 1; issue_addr = 12;
        rd_addr1 = 10; rd_addr2 = 31; #1;
        chk("T5_no_bypass_wr", rd_data1, 32'h0);
        chk("T5_no_bypass_link", rd_data2, 32'h40);
        tick();
        chk("T5_r10_held", rd_data1, 32'h0);
        chk("T5_r31_held", rd_data2, 32'h40);
        rd_addr1 = 12; #1;
        chk("T5_busy12_held", {31'b0, busy1}, 32'h0);
        freeze = 0; rd_addr1 = 10; #1;
        chk("T5_bypass_resumed", rd_data1, 32'hAAAA);
        tick();
        idle(); #1;
        chk("T5_r10", rd_data1, 32'hAAAA);
        chk("T5_r31", rd_data2, 32'h77);
        rd_addr1 = 12; #1;
        chk("T5_busy12", {31'b0, busy1}, 32'h1);

        // T6: reset mid-sequence discards busy state
        issue_en = 1; issue_addr = 3; tick();
        issue_addr = 7; tick();
        idle(); rd_addr1 = 3; rd_addr2 = 7; #1;
        chk("T6_busy3", {31'b0, busy1}, 32'h1);
        chk("T6_busy7", {31'b0, busy2}, 32'h1);
        reset = 1; freeze = 1; issue_en = 1; issue_addr = 3; wr_en = 1; wr_addr = 29; wr_data = 32'h1;
        tick();
        reset = 0; idle(); #1;
        chk("T6_busy3_rst", {31'b0, busy1}, 32'h0);
        chk("T6_busy7_rst", {31'b0, busy2}, 32'h0);
        rd_addr1 = 29; rd_addr2 = 5; #1;
        chk("T6_sp", rd_data1, 32'h00000FFC);
        chk("T6_sp_nb", nb_rd_data1, 32'h00000FFC);
        chk("T6_r5_cleared", rd_data2, 32'h0);
        rd_addr1 = 12; #1;
        chk("T6_busy12_rst", {31'b0, busy1}, 32'h0);
        wr_en = 1; wr_addr = 5; wr_data = 32'h5555; rd_addr1 = 5; #1;
        chk("T6_nb_old", nb_rd_data1, 32'h0);
        chk("T6_b_new", rd_data1, 32'h5555);
        tick();
        idle(); #1;
        chk("T6_nb_stored", nb_rd_data1, 32'h5555);
        chk("T6_b_stored", rd_data1, 32'h5555);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
